// File: rtl/mig_bram_loader.sv
// rtl/mig_bram_loader.sv - DDR read DMA: MIG bursts into a beat FIFO, unpacked into BRAM word writes
module mig_bram_loader #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int BRAM_ADDR_WIDTH = 9,
    parameter int BRAM_DIN_WIDTH  = 64,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [15:0]                i_num_beats,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_bram_base,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_ovf_err,
    output logic [ADDR_WIDTH-1:0]      o_addr,
    output logic                       o_arvalid,
    output logic                       o_awvalid,
    output logic [7:0]                 o_arwlen,
    input  logic                       i_arready,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_data_valid,
    input  logic                       i_rw_last,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
    output logic [BRAM_DIN_WIDTH-1:0]  o_bram_din,
    output logic                       o_bram_we
);
    localparam int WPB        = DATA_WIDTH / BRAM_DIN_WIDTH;
    localparam int WIDX_W     = $clog2(WPB);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [15:0]                r_remaining;
    logic [15:0]                w_chunk;
    logic                       r_done;
    logic                       r_ovf_err;
    logic [DATA_WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [PTR_W:0]             r_count;
    logic                       w_empty, w_full, w_push, w_pop;
    logic [DATA_WIDTH-1:0]      r_beat;
    logic                       r_upk_active;
    logic [WIDX_W-1:0]          r_word_idx;
    logic [BRAM_ADDR_WIDTH-1:0] r_bram_addr;
    logic                       w_upk_last, w_start_ok, w_burst_end, w_arvalid;

    assign w_chunk     = (r_remaining > 16'(FIFO_DEPTH)) ? 16'(FIFO_DEPTH) : r_remaining;
    assign w_start_ok  = i_start && (r_state == S_IDLE);
    assign w_burst_end = (r_state == S_DATA) && i_data_valid && i_rw_last;
    assign w_empty     = (r_count == '0);
    assign w_full      = (32'(r_count) == FIFO_DEPTH);
    assign w_push      = i_data_valid && (r_state == S_DATA) && !w_full;
    assign w_upk_last  = r_upk_active && (32'(r_word_idx) == WPB - 1);
    // Pop either into an idle unpacker or on its final word, so back-to-back beats stream without gaps.
    assign w_pop       = !w_empty && (!r_upk_active || w_upk_last);
    assign w_arvalid   = (r_state == S_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = (i_num_beats == 16'd0) ? S_DONE : S_ADDR;
            S_ADDR: if (i_arready) w_state_nxt = S_DATA;
            S_DATA: if (i_data_valid && i_rw_last) w_state_nxt = S_WAIT;
            S_WAIT: if (w_empty && (!r_upk_active || w_upk_last))
                        w_state_nxt = (r_remaining != 16'd0) ? S_ADDR : S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_bram_addr <= '0;
            r_done      <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_addr      <= i_base_addr;
                r_remaining <= i_num_beats;
                r_bram_addr <= i_bram_base;
            end else begin
                if (w_burst_end) begin
                    r_remaining <= r_remaining - w_chunk;
                    r_addr      <= r_addr + ADDR_WIDTH'(32'(w_chunk) * BEAT_BYTES);
                end
                if (r_upk_active) r_bram_addr <= r_bram_addr + BRAM_ADDR_WIDTH'(1);
            end
            r_done <= (r_state == S_DONE);
            if (i_data_valid && w_full) r_ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat       <= '0;
            r_upk_active <= 1'b0;
            r_word_idx   <= '0;
        end else if (w_pop) begin
            r_beat       <= r_mem[r_rd_ptr];
            r_upk_active <= 1'b1;
            r_word_idx   <= '0;
        end else if (r_upk_active) begin
            r_word_idx <= r_word_idx + WIDX_W'(1);
            if (w_upk_last) r_upk_active <= 1'b0;
        end
    end

    assign o_busy      = (r_state != S_IDLE) || r_done;
    assign o_done      = r_done;
    assign o_ovf_err   = r_ovf_err;
    assign o_addr      = r_addr;
    assign o_arvalid   = w_arvalid;
    assign o_awvalid   = 1'b0;
    assign o_arwlen    = w_arvalid ? 8'(w_chunk - 16'd1) : 8'd0;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_din  = r_upk_active ? r_beat[32'(r_word_idx) * BRAM_DIN_WIDTH +: BRAM_DIN_WIDTH] : '0;
    assign o_bram_we   = r_upk_active;
endmodule

// File: tb/tb_mig_bram_loader.sv
// tb/tb_mig_bram_loader.sv - directed vector bench with MIG responder and BRAM write scoreboard
module tb_mig_bram_loader;
    logic         clk = 1'b0;
    logic         i_rst, i_start, i_arready, i_data_valid, i_rw_last;
    logic [31:0]  i_base_addr;
    logic [15:0]  i_num_beats;
    logic [8:0]   i_bram_base;
    logic [511:0] i_data;
    logic         o_busy, o_done, o_ovf_err, o_arvalid, o_awvalid, o_bram_we;
    logic [31:0]  o_addr;
    logic [7:0]   o_arwlen;
    logic [8:0]   o_bram_addr;
    logic [63:0]  o_bram_din;

    int checks = 0;
    int errors = 0;
    logic [8:0]  sb_addr[$];
    logic [63:0] sb_din[$];

    always #5 clk = ~clk;

    mig_bram_loader dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_beats(i_num_beats), .i_bram_base(i_bram_base), .o_busy(o_busy),
        .o_done(o_done), .o_ovf_err(o_ovf_err), .o_addr(o_addr), .o_arvalid(o_arvalid),
        .o_awvalid(o_awvalid), .o_arwlen(o_arwlen), .i_arready(i_arready), .i_data(i_data),
        .i_data_valid(i_data_valid), .i_rw_last(i_rw_last), .o_bram_addr(o_bram_addr),
        .o_bram_din(o_bram_din), .o_bram_we(o_bram_we)
    );

    typedef struct {
        logic [31:0] base;
        logic [15:0] n;
        logic [8:0]  bbase;
        int          ar_delay;
        int          dup;
        int          exp_bursts;
        logic [31:0] exp_last_addr;
        logic [7:0]  exp_last_len;
        int          exp_writes;
        logic [8:0]  exp_end_baddr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] make_beat(input logic [31:0] a);
        logic [511:0] b;
        for (int k = 0; k < 8; k++) b[k*64 +: 64] = {a, 32'(k)};
        return b;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_ovf"}, o_ovf_err, 0);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_arvalid"}, o_arvalid, 0);
        chk({tag, "_awvalid"}, o_awvalid, 0);
        chk({tag, "_arwlen"}, o_arwlen, 0);
        chk({tag, "_bram_addr"}, o_bram_addr, 0);
        chk({tag, "_bram_din"}, o_bram_din, 0);
        chk({tag, "_bram_we"}, o_bram_we, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, n_bursts, n_writes, n_done, last_we, wait_cnt, beats_left, done_cyc, rem, c;
        logic [31:0] beat_addr, held_addr, exp_req_addr, last_addr;
        logic [7:0]  held_len, last_len;
        logic [8:0]  eb;
        logic        req_open;
        n_bursts = 0; n_writes = 0; n_done = 0; last_we = 0; wait_cnt = 0;
        beats_left = 0; done_cyc = -1; rem = int'(v.n); req_open = 1'b0;
        beat_addr = '0; held_addr = '0; held_len = '0; last_addr = '0; last_len = '0;
        exp_req_addr = v.base; eb = v.bbase;
        sb_addr.delete(); sb_din.delete();
        i_base_addr = v.base; i_num_beats = v.n; i_bram_base = v.bbase; i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        chk("busy_after_start", o_busy, 1);
        chk("arvalid_cycle1", o_arvalid, v.n != 0);
        forever begin
            if (o_bram_we) begin
                n_writes++;
                last_we = cyc;
                if (sb_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_without_beat actual=we@0x%0h required=no write", o_bram_addr);
                end else begin
                    chk("bram_addr", o_bram_addr, sb_addr.pop_front());
                    chk("bram_din", o_bram_din, sb_din.pop_front());
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("busy_low_after_done", o_busy, 0);
                chk("done_one_cycle", o_done, 0);
                break;
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
                if (v.n == 0) chk("done_latency_n0", cyc, 2);
                else          chk("done_within_2_of_last_we", (cyc - last_we) <= 2, 1);
            end
            if (o_arvalid) begin
                if (!req_open) begin
                    req_open = 1'b1;
                    n_bursts++;
                    held_addr = o_addr; held_len = o_arwlen;
                    last_addr = o_addr; last_len = o_arwlen;
                    chk("ar_addr", o_addr, exp_req_addr);
                    chk("ar_len", o_arwlen, 64'((rem > 8 ? 8 : rem) - 1));
                    wait_cnt = 0;
                end else begin
                    chk("ar_addr_stable", o_addr, held_addr);
                    chk("ar_len_stable", o_arwlen, held_len);
                end
            end
            i_data_valid = 1'b0; i_rw_last = 1'b0; i_arready = 1'b0; i_start = 1'b0;
            if (beats_left > 0) begin
                i_data_valid = 1'b1;
                i_data = make_beat(beat_addr);
                i_rw_last = (beats_left == 1);
                for (int k = 0; k < 8; k++) begin
                    sb_addr.push_back(eb);
                    sb_din.push_back({beat_addr, 32'(k)});
                    eb = eb + 9'd1;
                end
                beat_addr = beat_addr + 32'd64;
                beats_left--;
            end
            if (o_arvalid && req_open) begin
                if (wait_cnt >= v.ar_delay) begin
                    i_arready = 1'b1;
                    req_open = 1'b0;
                    c = int'(held_len) + 1;
                    beats_left = c;
                    beat_addr = held_addr;
                    rem = rem - c;
                    exp_req_addr = exp_req_addr + 32'(64 * c);
                end else begin
                    wait_cnt++;
                end
            end
            if (v.dup != 0 && cyc == 1) begin
                i_start = 1'b1; i_num_beats = 16'd4; i_base_addr = 32'h5000; i_bram_base = 9'h100;
            end
            if (cyc > 3000) begin
                checks++; errors++;
                $display("FAIL timeout actual=%0d cycles required=done", cyc);
                break;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        i_data_valid = 1'b0; i_rw_last = 1'b0; i_arready = 1'b0; i_start = 1'b0;
        chk("burst_count", n_bursts, v.exp_bursts);
        chk("last_burst_addr", last_addr, v.exp_last_addr);
        chk("last_burst_len", last_len, v.exp_last_len);
        chk("write_count", n_writes, v.exp_writes);
        chk("done_count", n_done, 1);
        chk("end_bram_addr", o_bram_addr, v.exp_end_baddr);
        chk("scoreboard_empty", sb_addr.size(), 0);
        chk("ovf_clear", o_ovf_err, 0);
    endtask

    initial begin
        vecs[0] = '{32'h1000, 16'd1,  9'h000, 0, 1, 1, 32'h1000, 8'd0, 8,   9'h008};
        vecs[1] = '{32'h0000, 16'd20, 9'h000, 0, 0, 3, 32'h0400, 8'd3, 160, 9'h0A0};
        vecs[2] = '{32'h2000, 16'd8,  9'h020, 5, 0, 1, 32'h2000, 8'd7, 64,  9'h060};
        vecs[3] = '{32'h0040, 16'd2,  9'h1F8, 0, 0, 1, 32'h0040, 8'd1, 16,  9'h008};
        vecs[4] = '{32'h3000, 16'd0,  9'h005, 0, 1, 0, 32'h0000, 8'd0, 0,   9'h005};

        i_rst = 1'b1; i_start = 1'b0; i_arready = 1'b0; i_data_valid = 1'b0; i_rw_last = 1'b0;
        i_base_addr = '0; i_num_beats = '0; i_bram_base = '0; i_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge clk);

        // Beats arriving while idle must be dropped without writes or overflow.
        i_data_valid = 1'b1; i_data = make_beat(32'hDEAD0000);
        repeat (2) @(negedge clk);
        i_data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("idle_beat_dropped", o_bram_we, 0);
            @(negedge clk);
        end
        chk("idle_beat_no_ovf", o_ovf_err, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort in the middle of a burst.
        i_base_addr = 32'h0; i_num_beats = 16'd8; i_bram_base = 9'h0; i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        chk("abort_arvalid", o_arvalid, 1);
        i_arready = 1'b1;
        @(negedge clk);
        i_arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            i_data_valid = 1'b1; i_rw_last = 1'b0; i_data = make_beat(32'(b * 64));
            @(negedge clk);
        end
        i_data_valid = 1'b0;
        chk("abort_writing", o_bram_we, 1);
        i_rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        run_vec('{32'h0800, 16'd1, 9'h010, 0, 0, 1, 32'h0800, 8'd0, 8, 9'h018});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
